// File: rtl/alu_core.sv
// Execute-stage ALU: 16 arithmetic/logic/shift/compare functions on unsigned
// WIDTH-bit operands, with the result and carry/flag registered (1-cycle latency).
module alu_core #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [3:0]       MUX_SELECT,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_INC  = 4'd2,
      OP_DEC  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_NAND = 4'd8,
      OP_NOR  = 4'd9,
      OP_XNOR = 4'd10,
      OP_SHL  = 4'd11,
      OP_SHR  = 4'd12,
      OP_ROL  = 4'd13,
      OP_ROR  = 4'd14,
      OP_CMP  = 4'd15
   } op_e;

   op_e              op;
   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   b_ext;
   logic [WIDTH:0]   cin_ext;
   logic [WIDTH:0]   one_ext;
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [WIDTH:0]   inc_full;
   logic [WIDTH:0]   dec_full;
   logic [WIDTH-1:0] res;
   logic             flag;

   assign op      = op_e'(MUX_SELECT);
   assign a_ext   = {1'b0, A};
   assign b_ext   = {1'b0, B};
   assign cin_ext = {{WIDTH{1'b0}}, CIN};
   assign one_ext = {{WIDTH{1'b0}}, 1'b1};

   // One extra bit on each arithmetic path: for SUB/DEC the top bit of the
   // two's-complement difference is exactly the borrow out.
   assign add_full = a_ext + b_ext + cin_ext;
   assign sub_full = a_ext - b_ext - cin_ext;
   assign inc_full = a_ext + one_ext;
   assign dec_full = a_ext - one_ext;

   always_comb begin
      res  = '0;
      flag = 1'b0;
      unique case (op)
         OP_ADD:  begin res = add_full[WIDTH-1:0]; flag = add_full[WIDTH]; end
         OP_SUB:  begin res = sub_full[WIDTH-1:0]; flag = sub_full[WIDTH]; end
         OP_INC:  begin res = inc_full[WIDTH-1:0]; flag = inc_full[WIDTH]; end
         OP_DEC:  begin res = dec_full[WIDTH-1:0]; flag = dec_full[WIDTH]; end
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_XOR:  res = A ^ B;
         OP_NOT:  res = ~A;
         OP_NAND: res = ~(A & B);
         OP_NOR:  res = ~(A | B);
         OP_XNOR: res = ~(A ^ B);
         OP_SHL:  begin res = {A[WIDTH-2:0], 1'b0};     flag = A[WIDTH-1]; end
         OP_SHR:  begin res = {1'b0, A[WIDTH-1:1]};     flag = A[0];       end
         OP_ROL:  begin res = {A[WIDTH-2:0], A[WIDTH-1]}; flag = A[WIDTH-1]; end
         OP_ROR:  begin res = {A[0], A[WIDTH-1:1]};     flag = A[0];       end
         OP_CMP:  begin
            res  = {{(WIDTH-1){1'b0}}, (A < B)};
            flag = (A == B);
         end
         default: begin res = '0; flag = 1'b0; end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         SUM  <= '0;
         COUT <= 1'b0;
      end else begin
         SUM  <= res;
         COUT <= flag;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table, reset sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu_core;

   localparam int unsigned WIDTH = 5;
   localparam int          M     = 1 << WIDTH;

   logic             CLK = 1'b0;
   logic             RST;
   logic [3:0]       MUX_SELECT;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
   logic [WIDTH-1:0] SUM;
   logic             COUT;

   int n_cmp = 0;
   int n_bad = 0;

   alu_core #(.WIDTH(WIDTH)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .MUX_SELECT (MUX_SELECT),
      .A          (A),
      .B          (B),
      .CIN        (CIN),
      .SUM        (SUM),
      .COUT       (COUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string            name;
      logic [3:0]       sel;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] exp_sum;
      logic             exp_cout;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, int sel, int a, int b, int cin, int s, int c);
      vec_t v;
      v.name     = name;
      v.sel      = 4'(sel);
      v.a        = WIDTH'(a);
      v.b        = WIDTH'(b);
      v.cin      = 1'(cin);
      v.exp_sum  = WIDTH'(s);
      v.exp_cout = 1'(c);
      return v;
   endfunction

   // Reference model from the operation definitions, using plain integer math.
   function automatic void ref_model(input int sel, input int a, input int b, input int cin,
                                     output int s, output int c);
      int t;
      s = 0;
      c = 0;
      case (sel)
         0:  begin t = a + b + cin; s = t % M; c = (t >= M) ? 1 : 0; end
         1:  begin t = a - b - cin; s = ((t % M) + M) % M; c = (a < b + cin) ? 1 : 0; end
         2:  begin s = (a + 1) % M; c = (a == M - 1) ? 1 : 0; end
         3:  begin s = (a + M - 1) % M; c = (a == 0) ? 1 : 0; end
         4:  s = a & b;
         5:  s = a | b;
         6:  s = a ^ b;
         7:  s = (M - 1) - a;
         8:  s = (M - 1) - (a & b);
         9:  s = (M - 1) - (a | b);
         10: s = (M - 1) - (a ^ b);
         11: begin s = (a * 2) % M; c = a / (M / 2); end
         12: begin s = a / 2; c = a % 2; end
         13: begin s = (a * 2) % M + a / (M / 2); c = a / (M / 2); end
         14: begin s = a / 2 + (a % 2) * (M / 2); c = a % 2; end
         default: begin s = (a < b) ? 1 : 0; c = (a == b) ? 1 : 0; end
      endcase
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] es, input logic ec);
      n_cmp++;
      if (SUM !== es || COUT !== ec) begin
         n_bad++;
         $display("FAIL %s: got SUM=%h COUT=%b, expected SUM=%h COUT=%b", name, SUM, COUT, es, ec);
      end
   endtask

   task automatic drive(input logic rst, input int sel, input int a, input int b, input int cin);
      RST        = rst;
      MUX_SELECT = 4'(sel);
      A          = WIDTH'(a);
      B          = WIDTH'(b);
      CIN        = 1'(cin);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int s, c, sel, a, b, cin, rst;

      // Test-plan vectors (A=0x08, B=0x11 sweeps, then wrap/carry boundaries)
      vecs.push_back(mk("add",   0,  8, 17, 0, 8'h19, 0));
      vecs.push_back(mk("sub",   1,  8, 17, 0, 8'h17, 1));
      vecs.push_back(mk("inc",   2,  8, 17, 0, 8'h09, 0));
      vecs.push_back(mk("dec",   3,  8, 17, 0, 8'h07, 0));
      vecs.push_back(mk("and",   4,  8, 17, 0, 8'h00, 0));
      vecs.push_back(mk("or",    5,  8, 17, 0, 8'h19, 0));
      vecs.push_back(mk("xor",   6,  8, 17, 0, 8'h19, 0));
      vecs.push_back(mk("not",   7,  8, 17, 0, 8'h17, 0));
      vecs.push_back(mk("nand",  8,  8, 17, 0, 8'h1F, 0));
      vecs.push_back(mk("nor",   9,  8, 17, 0, 8'h06, 0));
      vecs.push_back(mk("xnor", 10,  8, 17, 0, 8'h06, 0));
      vecs.push_back(mk("shl",  11,  8, 17, 0, 8'h10, 0));
      vecs.push_back(mk("shr",  12,  8, 17, 0, 8'h04, 0));
      vecs.push_back(mk("rol",  13,  8, 17, 0, 8'h10, 0));
      vecs.push_back(mk("ror",  14,  8, 17, 0, 8'h04, 0));
      vecs.push_back(mk("cmp",  15,  8, 17, 0, 8'h01, 0));
      vecs.push_back(mk("add_wrap", 0, 8'h1F, 1, 1, 8'h01, 1));
      vecs.push_back(mk("inc_wrap", 2, 8'h1F, 0, 0, 8'h00, 1));
      vecs.push_back(mk("dec_wrap", 3, 0,     0, 0, 8'h1F, 1));
      vecs.push_back(mk("sub_borrow", 1, 5,   5, 1, 8'h1F, 1));
      vecs.push_back(mk("cmp_eq",  15, 8'h0A, 8'h0A, 0, 8'h00, 1));
      vecs.push_back(mk("shl_out", 11, 8'h11, 0, 0, 8'h02, 1));
      vecs.push_back(mk("ror_out", 14, 8'h01, 0, 0, 8'h10, 1));
      vecs.push_back(mk("inc_cin_ignored", 2, 3, 0, 1, 8'h04, 0));
      vecs.push_back(mk("and_cin_ignored", 4, 8'h1F, 8'h0C, 1, 8'h0C, 0));

      // Reset held for two edges, then released
      drive(1, 0, 8, 17, 0);
      tick(); check("reset_edge1", '0, 1'b0);
      tick(); check("reset_edge2", '0, 1'b0);
      drive(0, 0, 8, 17, 0);
      tick(); check("reset_release_add", 5'h19, 1'b0);

      foreach (vecs[i]) begin
         drive(0, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
         tick();
         check(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cout);
      end

      // Reset mid-stream of back-to-back ADDs discards that cycle's operation
      drive(0, 0, 8'h1F, 8'h1F, 1);
      tick(); check("mid_add_before", 5'h1F, 1'b1);
      drive(1, 0, 3, 4, 0);
      tick(); check("mid_reset", '0, 1'b0);
      drive(0, 0, 6, 7, 0);
      tick(); check("mid_add_after", 5'h0D, 1'b0);
      drive(0, 0, 1, 1, 1);
      tick(); check("mid_add_next", 5'h03, 1'b0);

      // Outputs hold between edges: change inputs without a clock edge
      drive(0, 7, 0, 0, 0);
      #3; check("hold_no_comb_path", 5'h03, 1'b0);
      tick(); check("hold_then_not", 5'h1F, 1'b0);

      // Randomized stream with occasional resets
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 15));
         a   = int'($urandom_range(0, M - 1));
         b   = int'($urandom_range(0, M - 1));
         cin = int'($urandom_range(0, 1));
         rst = ($urandom_range(0, 19) == 0) ? 1 : 0;
         if (rst == 1) begin
            s = 0;
            c = 0;
         end else begin
            ref_model(sel, a, b, cin, s, c);
         end
         drive(1'(rst), sel, a, b, cin);
         tick();
         check($sformatf("rand%0d_sel%0d", i, sel), WIDTH'(s), 1'(c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
